dnn_output_evaluator: RTL and testbench

- Synthesizable stream consumer placed directly downstream of the DNN output layer. It replaces the simulation-only accuracy bookkeeping with hardware counters.
- Tracks the block cycle. Samples one output neuron per clock, both the thresholded actual output, the ideal output and the raw activation. Produces a per-training-case verdict.
- Maintains running statistics: case count, total errors, and correct cases within the most recent WINDOW cases. These are read by the host and the debug logger.

---
 rtl/dnn_output_evaluator.sv | 141 ++++++++++++++
 tb/tb_dnn_output_evaluator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_output_evaluator.sv
// Streaming evaluator for the DNN output layer: it compares one neuron per clock against the
// ideal output and keeps per-case verdicts plus running accuracy statistics.
module dnn_output_evaluator #(
  parameter int width       = 32,
  parameter int frac_bits   = 21,
  parameter int cpc         = 18,
  parameter int n_out       = 16,
  parameter int num_classes = 10,
  parameter int window      = 100
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clear_stats,
  input  logic                                   a_out,
  input  logic                                   y_out,
  input  logic [width-1:0]                       act_l,
  output logic [$clog2(cpc)-1:0]                 cycle_index,
  output logic                                   case_done,
  output logic                                   case_error,
  output logic                                   case_correct,
  output logic [width+$clog2(n_out)+1-1:0]       case_abs_err,
  output logic [31:0]                            num_cases,
  output logic [31:0]                            total_errors,
  output logic [$clog2(window+1)-1:0]            recent_correct
);

  localparam int CW = $clog2(cpc);
  localparam int AW = width + $clog2(n_out) + 1;
  localparam int RW = $clog2(window + 1);
  localparam int W1 = width + 1;
  localparam logic signed [width:0]   ONE     = W1'(1) << frac_bits;
  localparam logic signed [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

  function automatic logic [width:0] abs_mag(input logic signed [width:0] d);
    return d[width] ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic                    err_acc;
  logic [AW-1:0]           abs_acc;
  logic signed [width-1:0] max_val;
  logic [CW-1:0]           max_idx;
  logic [CW-1:0]           ideal_idx;
  logic                    ideal_vld;
  logic [window-1:0]       win_bits;

  logic                    vld_p0;
  logic [CW-1:0]           k_p0;
  logic                    cls_p0;
  logic                    last_p0;
  logic signed [width-1:0] act_s;
  logic signed [width:0]   diff_p0;
  logic                    err_fin;
  logic [AW-1:0]           abs_fin;
  logic                    upd_max;
  logic                    cap_ideal;
  logic [CW-1:0]           idx_fin;
  logic [CW-1:0]           ideal_fin;
  logic                    ideal_vld_fin;
  logic                    correct_fin;

  // Stage 0: fold the current sample into the running case state combinationally so the
  // finalize edge sees accumulators that already include the last neuron.
  always_comb begin
    act_s         = act_l;
    vld_p0        = cycle_index >= CW'(2);
    k_p0          = cycle_index - CW'(2);
    cls_p0        = vld_p0 && (k_p0 < CW'(num_classes));
    last_p0       = cycle_index == CW'(cpc - 1);
    diff_p0       = {act_s[width-1], act_s} - (y_out ? ONE : W1'(0));
    err_fin       = err_acc | (vld_p0 & (a_out ^ y_out));
    abs_fin       = abs_acc + (vld_p0 ? AW'(abs_mag(diff_p0)) : AW'(0));
    upd_max       = cls_p0 && (act_s > max_val);
    cap_ideal     = cls_p0 && y_out && !ideal_vld;
    idx_fin       = upd_max ? k_p0 : max_idx;
    ideal_fin     = cap_ideal ? k_p0 : ideal_idx;
    ideal_vld_fin = ideal_vld | cap_ideal;
    correct_fin   = ideal_vld_fin && (idx_fin == ideal_fin);
  end

  // Stage 1: registered case state, verdicts and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_index    <= '0;
      case_done      <= 1'b0;
      case_error     <= 1'b0;
      case_correct   <= 1'b0;
      case_abs_err   <= '0;
      num_cases      <= '0;
      total_errors   <= '0;
      recent_correct <= '0;
      win_bits       <= '0;
      err_acc        <= 1'b0;
      abs_acc        <= '0;
      max_val        <= MOST_NEG;
      max_idx        <= '0;
      ideal_idx      <= '0;
      ideal_vld      <= 1'b0;
    end else begin
      cycle_index <= last_p0 ? '0 : cycle_index + CW'(1);
      case_done   <= last_p0;
      if (last_p0) begin
        case_error     <= err_fin;
        case_abs_err   <= abs_fin;
        case_correct   <= correct_fin;
        err_acc        <= 1'b0;
        abs_acc        <= '0;
        max_val        <= MOST_NEG;
        max_idx        <= '0;
        ideal_idx      <= '0;
        ideal_vld      <= 1'b0;
        num_cases      <= sat_inc(num_cases, 1'b1);
        total_errors   <= sat_inc(total_errors, err_fin);
        win_bits       <= {win_bits[window-2:0], correct_fin};
        recent_correct <= recent_correct + RW'(correct_fin) - RW'(win_bits[window-1]);
      end else begin
        err_acc <= err_fin;
        abs_acc <= abs_fin;
        if (upd_max) begin
          max_val <= act_s;
          max_idx <= k_p0;
        end
        if (cap_ideal) begin
          ideal_idx <= k_p0;
          ideal_vld <= 1'b1;
        end
      end
      // A clear on the finalize edge overrides that case's statistics update.
      if (clear_stats) begin
        num_cases      <= '0;
        total_errors   <= '0;
        recent_correct <= '0;
        win_bits       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dnn_output_evaluator.sv
// Directed bench for dnn_output_evaluator: drives whole cases neuron by neuron and checks verdicts and stats.
module tb_dnn_output_evaluator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_stats;
  logic        a_out;
  logic        y_out;
  logic [31:0] act_l;
  logic [4:0]  cycle_index;
  logic        case_done;
  logic        case_error;
  logic        case_correct;
  logic [36:0] case_abs_err;
  logic [31:0] num_cases;
  logic [31:0] total_errors;
  logic [6:0]  recent_correct;

  int tests_run = 0;
  int fails = 0;

  logic [15:0] a_v;
  logic [15:0] y_v;
  logic [31:0] act_v [16];

  dnn_output_evaluator dut (
    .clk(clk), .reset(reset), .clear_stats(clear_stats), .a_out(a_out), .y_out(y_out),
    .act_l(act_l), .cycle_index(cycle_index), .case_done(case_done), .case_error(case_error),
    .case_correct(case_correct), .case_abs_err(case_abs_err), .num_cases(num_cases),
    .total_errors(total_errors), .recent_correct(recent_correct)
  );

  always #5 clk = ~clk;

  task automatic set_case(input int ideal, input int hot);
    a_v = '0;
    y_v = '0;
    for (int i = 0; i < 16; i++) act_v[i] = 32'h0;
    y_v[ideal] = 1'b1;
    a_v[ideal] = 1'b1;
    act_v[hot] = 32'h0020_0000;
  endtask

  // Called at a negedge; returns at the negedge where the case results are visible.
  task automatic run_case(input bit clr_last);
    int n;
    n = 0;
    while (cycle_index !== 5'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      fails++;
      $display("FAIL sync: cycle_index=%0d never reached 2", cycle_index);
    end
    tests_run++;
    for (int k = 0; k < 16; k++) begin
      a_out = a_v[k];
      y_out = y_v[k];
      act_l = act_v[k];
      clear_stats = (k == 15) ? clr_last : 1'b0;
      @(negedge clk);
    end
    a_out = 1'b0;
    y_out = 1'b0;
    act_l = 32'h0;
    clear_stats = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_stats = 1'b0;
    repeat (3) begin
      a_out = 1'($urandom);
      y_out = 1'($urandom);
      act_l = $urandom;
      @(negedge clk);
    end
    tests_run++;
    if ({cycle_index, case_done, case_error, case_correct} !== 8'h0) begin
      fails++;
      $display("FAIL reset_ctrl: got ci=%0d done=%b err=%b cor=%b, want 0", cycle_index, case_done, case_error, case_correct);
    end
    tests_run++;
    if (case_abs_err !== 37'h0 || num_cases !== 32'h0 || total_errors !== 32'h0 || recent_correct !== 7'h0) begin
      fails++;
      $display("FAIL reset_stats: abs=%h cases=%0d errs=%0d recent=%0d, want 0", case_abs_err, num_cases, total_errors, recent_correct);
    end
    reset = 1'b0;
    a_out = 1'b0;
    y_out = 1'b0;
    act_l = 32'h0;
    #1;
    tests_run++;
    if (cycle_index !== 5'd0) begin
      fails++;
      $display("FAIL release_ci0: got %0d want 0", cycle_index);
    end
    @(negedge clk);
    tests_run++;
    if (cycle_index !== 5'd1) begin
      fails++;
      $display("FAIL release_ci1: got %0d want 1", cycle_index);
    end
  endtask

  task automatic test_perfect();
    set_case(3, 3);
    run_case(1'b0);
    tests_run++;
    if (case_done !== 1'b1 || cycle_index !== 5'd0) begin
      fails++;
      $display("FAIL perfect_done: done=%b ci=%0d want 1/0", case_done, cycle_index);
    end
    tests_run++;
    if (case_error !== 1'b0 || case_correct !== 1'b1 || case_abs_err !== 37'h0) begin
      fails++;
      $display("FAIL perfect_verdict: err=%b cor=%b abs=%h want 0/1/0", case_error, case_correct, case_abs_err);
    end
    tests_run++;
    if (num_cases !== 32'd1 || total_errors !== 32'd0 || recent_correct !== 7'd1) begin
      fails++;
      $display("FAIL perfect_stats: cases=%0d errs=%0d recent=%0d want 1/0/1", num_cases, total_errors, recent_correct);
    end
    @(negedge clk);
    tests_run++;
    if (case_done !== 1'b0 || case_correct !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: done=%b cor=%b want 0/1", case_done, case_correct);
    end
  endtask

  task automatic test_last_mismatch();
    set_case(3, 3);
    a_v[15] = 1'b1;
    run_case(1'b0);
    tests_run++;
    if (case_error !== 1'b1 || total_errors !== 32'd1 || num_cases !== 32'd2) begin
      fails++;
      $display("FAIL last_mismatch: err=%b errs=%0d cases=%0d want 1/1/2", case_error, total_errors, num_cases);
    end
  endtask

  task automatic test_argmax_tie();
    set_case(5, 5);
    act_v[5] = 32'h0010_0000;
    act_v[2] = 32'h0010_0000;
    run_case(1'b0);
    tests_run++;
    if (case_correct !== 1'b0 || case_error !== 1'b0) begin
      fails++;
      $display("FAIL tie_ideal5: cor=%b err=%b want 0/0", case_correct, case_error);
    end
    set_case(2, 2);
    act_v[2] = 32'h0010_0000;
    act_v[5] = 32'h0010_0000;
    run_case(1'b0);
    tests_run++;
    if (case_correct !== 1'b1 || num_cases !== 32'd4 || recent_correct !== 7'd3) begin
      fails++;
      $display("FAIL tie_ideal2: cor=%b cases=%0d recent=%0d want 1/4/3", case_correct, num_cases, recent_correct);
    end
  endtask

  task automatic test_abs_err();
    set_case(0, 0);
    act_v[0] = 32'hFFF0_0000;
    for (int i = 1; i < 16; i++) act_v[i] = 32'h0008_0000;
    run_case(1'b0);
    tests_run++;
    if (case_abs_err !== 37'h0_00A8_0000) begin
      fails++;
      $display("FAIL abs_err: got %h want 00a80000", case_abs_err);
    end
    tests_run++;
    if (case_correct !== 1'b0 || case_error !== 1'b0 || total_errors !== 32'd1) begin
      fails++;
      $display("FAIL abs_verdict: cor=%b err=%b errs=%0d want 0/0/1", case_correct, case_error, total_errors);
    end
  endtask

  task automatic test_window();
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    tests_run++;
    if (num_cases !== 32'd0 || recent_correct !== 7'd0 || total_errors !== 32'd0) begin
      fails++;
      $display("FAIL clear_idle: cases=%0d recent=%0d errs=%0d want 0", num_cases, recent_correct, total_errors);
    end
    for (int i = 0; i < 150; i++) begin
      if (i % 2 == 0) set_case(3, 3);
      else set_case(3, 4);
      run_case(1'b0);
      if (i == 99) begin
        tests_run++;
        if (recent_correct !== 7'd50 || num_cases !== 32'd100) begin
          fails++;
          $display("FAIL window_100: recent=%0d cases=%0d want 50/100", recent_correct, num_cases);
        end
      end
    end
    tests_run++;
    if (recent_correct !== 7'd50 || num_cases !== 32'd150 || total_errors !== 32'd0) begin
      fails++;
      $display("FAIL window_150: recent=%0d cases=%0d errs=%0d want 50/150/0", recent_correct, num_cases, total_errors);
    end
    set_case(3, 3);
    a_v[0] = 1'b1;
    run_case(1'b1);
    tests_run++;
    if (num_cases !== 32'd0 || recent_correct !== 7'd0 || total_errors !== 32'd0) begin
      fails++;
      $display("FAIL clear_finalize: cases=%0d recent=%0d errs=%0d want 0", num_cases, recent_correct, total_errors);
    end
    tests_run++;
    if (case_done !== 1'b1 || case_error !== 1'b1 || case_correct !== 1'b1) begin
      fails++;
      $display("FAIL clear_case_out: done=%b err=%b cor=%b want 1/1/1", case_done, case_error, case_correct);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_stats = 1'b0;
    a_out = 1'b0;
    y_out = 1'b0;
    act_l = 32'h0;
    @(negedge clk);
    test_reset();
    test_perfect();
    test_last_mismatch();
    test_argmax_tie();
    test_abs_err();
    test_window();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
